// File: rtl/gauss_ctrl.sv
// gauss_ctrl: sequences the Gauss n(n+1)/2 unit (init / add / decrement loop)
// between a valid/ready issue port and a valid/ready writeback port.
module gauss_ctrl #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             preset,
    input  logic             flush,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [width-1:0] issue_data,
    output logic [2:0]       ctrlword,
    output logic [width-1:0] unit_data,
    output logic             unit_preset,
    input  logic             status,
    input  logic             done,
    input  logic             prediction,
    input  logic [width-1:0] result,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [width-1:0] wb_data,
    output logic             err
);
    typedef enum logic [2:0] {IDLE, INIT, ACC, DEC, WB} state_t;
    state_t             state_q, state_d;
    logic [width-1:0]   opnd_q, opnd_d;
    logic [width-1:0]   wb_data_q, wb_data_d;
    logic               err_q, err_d;
    always_comb begin
        state_d   = state_q;
        opnd_d    = opnd_q;
        wb_data_d = wb_data_q;
        err_d     = err_q | (state_q == IDLE && status);
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (issue_valid) begin
                             state_d = INIT;
                             opnd_d  = issue_data;
                         end
                INIT:    state_d = ACC;
                ACC:     state_d = done ? WB : DEC;
                DEC:     state_d = prediction ? WB : ACC;
                WB:      state_d = wb_ready ? IDLE : WB;
                default: state_d = IDLE;
            endcase
            // the accumulator is final on the edge that enters WB
            if (state_d == WB && state_q != WB) wb_data_d = result;
        end
    end
    always_ff @(posedge clk or negedge preset) begin
        if (!preset) begin
            state_q   <= IDLE;
            opnd_q    <= '0;
            wb_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            opnd_q    <= opnd_d;
            wb_data_q <= wb_data_d;
            err_q     <= err_d;
        end
    end
    assign ctrlword    = flush                      ? 3'b000 :
                         state_q == INIT            ? 3'b001 :
                         (state_q == ACC && !done)  ? 3'b010 :
                         state_q == DEC             ? 3'b100 : 3'b000;
    assign issue_ready = state_q == IDLE;
    assign wb_valid    = state_q == WB;
    assign wb_data     = wb_data_q;
    assign unit_data   = opnd_q;
    assign unit_preset = ~preset;
    assign err         = err_q;
endmodule

// File: tb/tb_gauss_ctrl.sv
// tb_gauss_ctrl: directed checks of gauss_ctrl against a behavioural Gauss
// unit, with a 16-bit and an 8-bit instance.
module tb_gauss_ctrl;
    logic        clk = 1'b0;
    logic        preset, flush, issue_valid, wb_ready;
    logic [15:0] issue_data;
    logic        issue_ready, unit_preset, wb_valid, err;
    logic [2:0]  ctrlword;
    logic [15:0] unit_data, wb_data;
    logic [15:0] u_n, u_acc;
    logic        u_pred, poke;
    logic [15:0] poke_val;
    logic        issue_valid8, wb_ready8, flush8;
    logic [7:0]  issue_data8;
    logic        issue_ready8, unit_preset8, wb_valid8, err8;
    logic [2:0]  ctrlword8;
    logic [7:0]  unit_data8, wb_data8;
    logic [7:0]  v_n, v_acc;
    logic        v_pred;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    gauss_ctrl #(.width(16)) dut (
        .clk(clk), .preset(preset), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_data(issue_data),
        .ctrlword(ctrlword), .unit_data(unit_data), .unit_preset(unit_preset),
        .status(u_n != 16'd0), .done(u_n == 16'd0), .prediction(u_pred), .result(u_acc),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .err(err)
    );

    gauss_ctrl #(.width(8)) dut8 (
        .clk(clk), .preset(preset), .flush(flush8),
        .issue_valid(issue_valid8), .issue_ready(issue_ready8), .issue_data(issue_data8),
        .ctrlword(ctrlword8), .unit_data(unit_data8), .unit_preset(unit_preset8),
        .status(v_n != 8'd0), .done(v_n == 8'd0), .prediction(v_pred), .result(v_acc),
        .wb_valid(wb_valid8), .wb_ready(wb_ready8), .wb_data(wb_data8), .err(err8)
    );

    // behavioural Gauss units: init loads n and zeroes acc, add accumulates n, dec decrements n
    always_ff @(posedge clk) begin
        if (unit_preset) begin
            u_n <= '0; u_acc <= '0; u_pred <= 1'b0;
        end else if (poke) begin
            u_n <= poke_val; u_pred <= 1'b0;
        end else begin
            u_pred <= ctrlword[1] && u_n == 16'd1;
            if (ctrlword[0]) begin u_n <= unit_data; u_acc <= '0; end
            if (ctrlword[1]) u_acc <= u_acc + u_n;
            if (ctrlword[2]) u_n <= u_n - 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (unit_preset8) begin
            v_n <= '0; v_acc <= '0; v_pred <= 1'b0;
        end else begin
            v_pred <= ctrlword8[1] && v_n == 8'd1;
            if (ctrlword8[0]) begin v_n <= unit_data8; v_acc <= '0; end
            if (ctrlword8[1]) v_acc <= v_acc + v_n;
            if (ctrlword8[2]) v_n <= v_n - 8'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // one 16-bit job with wb_ready high: checks the control word every cycle,
    // the WB entry cycle (2N+1 after accept, 2 for N=0) and the return to IDLE
    task automatic job(input int n, input logic [15:0] exp);
        issue_valid = 1'b1;
        issue_data  = 16'(n);
        step();
        issue_valid = 1'b0;
        #1 chk($sformatf("init_cw_n%0d", n), 32'(ctrlword), 32'd1);
        if (n == 0) begin
            step();
            chk("acc_done_cw", 32'(ctrlword), 32'd0);
        end else begin
            for (int i = 0; i < n; i++) begin
                step();
                chk($sformatf("acc_cw_n%0d_%0d", n, i), 32'(ctrlword), 32'd2);
                chk($sformatf("acc_wbv_n%0d_%0d", n, i), 32'(wb_valid), 32'd0);
                step();
                chk($sformatf("dec_cw_n%0d_%0d", n, i), 32'(ctrlword), 32'd4);
            end
        end
        step();
        chk($sformatf("wb_valid_n%0d", n), 32'(wb_valid), 32'd1);
        chk($sformatf("wb_data_n%0d", n), 32'(wb_data), 32'(exp));
        chk($sformatf("wb_cw_n%0d", n), 32'(ctrlword), 32'd0);
        chk($sformatf("wb_irdy_n%0d", n), 32'(issue_ready), 32'd0);
        step();
        chk($sformatf("idle_irdy_n%0d", n), 32'(issue_ready), 32'd1);
        chk($sformatf("idle_wbv_n%0d", n), 32'(wb_valid), 32'd0);
    endtask

    initial begin
        preset = 1'b0; flush = 1'b0; issue_valid = 1'b0; wb_ready = 1'b1; issue_data = '0;
        poke = 1'b0; poke_val = '0;
        issue_valid8 = 1'b0; wb_ready8 = 1'b0; flush8 = 1'b0; issue_data8 = '0;
        step(); step();
        chk("rst_cw", 32'(ctrlword), 32'd0);
        chk("rst_irdy", 32'(issue_ready), 32'd1);
        chk("rst_wbv", 32'(wb_valid), 32'd0);
        chk("rst_wbd", 32'(wb_data), 32'd0);
        chk("rst_udata", 32'(unit_data), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_upreset", 32'(unit_preset), 32'd1);
        preset = 1'b1;
        #1 chk("run_upreset", 32'(unit_preset), 32'd0);
        step();

        job(4, 16'd10);
        job(0, 16'd0);
        job(1, 16'd1);
        job(3, 16'd6);
        job(7, 16'd28);
        chk("err_clean", 32'(err), 32'd0);

        // flush in IDLE beats a pending operand
        flush = 1'b1; issue_valid = 1'b1; issue_data = 16'd9;
        #1 chk("flush_idle_cw", 32'(ctrlword), 32'd0);
        step();
        flush = 1'b0; issue_valid = 1'b0;
        #1 chk("flush_idle_irdy", 32'(issue_ready), 32'd1);
        chk("flush_idle_cw2", 32'(ctrlword), 32'd0);

        // N=6 aborted in the third ACC
        issue_valid = 1'b1; issue_data = 16'd6;
        step();
        issue_valid = 1'b0;
        repeat (5) step();
        chk("acc3_cw", 32'(ctrlword), 32'd2);
        flush = 1'b1;
        #1 chk("flush_acc_cw", 32'(ctrlword), 32'd0);
        step();
        flush = 1'b0;
        #1 chk("flush_acc_irdy", 32'(issue_ready), 32'd1);
        chk("flush_acc_wbv", 32'(wb_valid), 32'd0);
        chk("flush_acc_wbd", 32'(wb_data), 32'd28);
        job(2, 16'd3);
        chk("err_stale_n", 32'(err), 32'd1);

        // 8-bit instance: N=30 wraps to 209, writeback stalled 5 cycles
        issue_valid8 = 1'b1; issue_data8 = 8'd30;
        step();
        issue_valid8 = 1'b0;
        repeat (60) step();
        chk("w8_pre_wbv", 32'(wb_valid8), 32'd0);
        step();
        chk("w8_wbv", 32'(wb_valid8), 32'd1);
        chk("w8_wbd", 32'(wb_data8), 32'd209);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("w8_hold_wbv_%0d", i), 32'(wb_valid8), 32'd1);
            chk($sformatf("w8_hold_wbd_%0d", i), 32'(wb_data8), 32'd209);
            chk($sformatf("w8_hold_irdy_%0d", i), 32'(issue_ready8), 32'd0);
        end
        wb_ready8 = 1'b1;
        step();
        chk("w8_idle_irdy", 32'(issue_ready8), 32'd1);
        chk("w8_idle_wbv", 32'(wb_valid8), 32'd0);

        // reset in the middle of an N=5 job, then a stale n=2 in the unit
        issue_valid = 1'b1; issue_data = 16'd5;
        step();
        issue_valid = 1'b0;
        step(); step();
        chk("mid_dec_cw", 32'(ctrlword), 32'd4);
        preset = 1'b0;
        #1 chk("mid_rst_cw", 32'(ctrlword), 32'd0);
        chk("mid_rst_irdy", 32'(issue_ready), 32'd1);
        chk("mid_rst_wbv", 32'(wb_valid), 32'd0);
        chk("mid_rst_wbd", 32'(wb_data), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_udata", 32'(unit_data), 32'd0);
        chk("mid_rst_upreset", 32'(unit_preset), 32'd1);
        step(); step();
        chk("mid_rst_unit_n", 32'(u_n), 32'd0);
        preset = 1'b1; poke = 1'b1; poke_val = 16'd2;
        step();
        poke = 1'b0;
        chk("stale_err_pre", 32'(err), 32'd0);
        step();
        chk("stale_err", 32'(err), 32'd1);
        chk("stale_wbv", 32'(wb_valid), 32'd0);
        step();
        chk("stale_err_sticky", 32'(err), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
